cover_toggle_drain: RTL



---
 rtl/cover_toggle_drain.sv | 111 +++++++++++
 1 files changed

// File: rtl/cover_toggle_drain.sv
// Toggle-coverage drain: captures per-bit hit pulses and reports each uncovered
// bit once, lowest index first, over a valid/ready channel.
module cover_toggle_drain #(
  parameter int unsigned WIDTH       = 29,
  parameter logic [63:0] COVER_INDEX = 64'd0,
  parameter int unsigned CNT_W       = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] valid,
  input  logic             enable,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_index,
  output logic [CNT_W-1:0] covered_count,
  output logic             all_covered
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_pending;
  logic [WIDTH-1:0]   r_covered;
  logic               r_out_valid;
  logic [63:0]        r_out_index;
  logic [CNT_W-1:0]   r_count;

  logic [WIDTH-1:0]   w_cand;
  logic [WIDTH-1:0]   w_sel_mask;
  logic [WIDTH-1:0]   w_take_mask;
  logic [WIDTH-1:0]   w_capture;
  logic [IDX_W-1:0]   w_sel_idx;
  logic               w_found;
  logic               w_handshake;
  logic               w_take;

  // Candidates come from registered state only, so same-cycle hits wait a cycle.
  assign w_cand      = r_pending & ~r_covered;
  assign w_handshake = r_out_valid & out_ready;
  assign w_take      = ~clear & w_found & ((r_state == S_IDLE) | w_handshake);
  assign w_take_mask = w_take ? w_sel_mask : '0;
  assign w_capture   = (enable & ~clear) ? (valid & ~r_covered) : '0;

  // Fixed-priority pick of the lowest pending, uncovered bit.
  always_comb begin
    w_sel_mask = '0;
    w_sel_idx  = '0;
    w_found    = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_cand[i] && !w_found) begin
        w_found       = 1'b1;
        w_sel_idx     = IDX_W'(i);
        w_sel_mask[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_pending   <= '0;
      r_covered   <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_index <= '0;
    end else begin
      if (clear) begin
        r_pending <= '0;
        r_covered <= '0;
        r_count   <= '0;
      end else begin
        // A hit on the bit being selected is masked out, so it cannot re-pend.
        r_pending <= (r_pending | w_capture) & ~w_take_mask;
        r_covered <= r_covered | w_take_mask;
        if (w_take) begin
          r_count <= r_count + CNT_W'(1);
        end
      end

      if (r_state == S_IDLE) begin
        if (w_take) begin
          r_state     <= S_EMIT;
          r_out_valid <= 1'b1;
          r_out_index <= COVER_INDEX + 64'(w_sel_idx);
        end
      end else begin
        // A report already on the channel survives clear; only reset drops it.
        if (w_handshake) begin
          if (w_take) begin
            r_out_index <= COVER_INDEX + 64'(w_sel_idx);
          end else begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end
      end
    end
  end

  assign out_valid     = r_out_valid;
  assign out_index     = r_out_index;
  assign covered_count = r_count;
  assign all_covered   = (r_count == CNT_W'(WIDTH));

endmodule
